// File: rtl/bomb_game_ctrl.sv
// Game sequencer for the bomb-dismantlement game: gates on the master switch, runs
// SHOW/INPUT rounds with a free-running LFSR code source, counts strikes and holds WIN/LOSE.
`timescale 1ns/1ps
module bomb_game_ctrl #(
  parameter int CODE_W       = 5,
  parameter int TIME_W       = 5,
  parameter int SHOW_SEC     = 5,
  parameter int INPUT_SEC    = 20,
  parameter int ROUNDS       = 3,
  parameter int ROUND_W      = 2,
  parameter int MAX_STRIKES  = 2,
  parameter int END_SEC      = 3,
  parameter int AUTO_RESTART = 1
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               enable,
  input  logic               start_btn,
  input  logic               tick,
  input  logic               code_ok,
  input  logic               code_bad,
  output logic               sub_rst,
  output logic               bomb_en,
  output logic               show_en,
  output logic               input_en,
  output logic               timer_en,
  output logic [CODE_W-1:0]  code,
  output logic [TIME_W-1:0]  secs_left,
  output logic [ROUND_W-1:0] round,
  output logic [1:0]         strikes,
  output logic               win,
  output logic               lose
);

  typedef enum logic [2:0] {S_OFF, S_IDLE, S_ARM, S_SHOW, S_INPUT, S_WIN, S_LOSE} state_t;

  localparam logic [TIME_W-1:0]  SHOW_T     = TIME_W'(SHOW_SEC);
  localparam logic [TIME_W-1:0]  INPUT_T    = TIME_W'(INPUT_SEC);
  localparam logic [TIME_W-1:0]  END_T      = TIME_W'(END_SEC);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);
  localparam logic [1:0]         STRIKE_LIM = 2'(MAX_STRIKES);

  state_t              state, nxt;
  logic [15:0]         lfsr;
  logic                start_prev, rst_pend;
  logic [TIME_W-1:0]   hold_cnt, hold_nxt, secs_nxt, secs_dec;
  logic [CODE_W-1:0]   code_nxt;
  logic [ROUND_W-1:0]  round_nxt;
  logic [1:0]          strikes_nxt, strikes_inc;
  logic                sub_rst_nxt;
  logic                start_rise, start_fall, final_tick;

  assign start_rise  = start_btn & ~start_prev;
  assign start_fall  = ~start_btn & start_prev;
  assign final_tick  = tick && (secs_left == TIME_W'(1));
  assign secs_dec    = (secs_left != '0) ? secs_left - TIME_W'(1) : secs_left;
  assign strikes_inc = strikes + 2'd1;

  always_comb begin
    nxt         = state;
    secs_nxt    = secs_left;
    hold_nxt    = hold_cnt;
    code_nxt    = code;
    round_nxt   = round;
    strikes_nxt = strikes;
    sub_rst_nxt = rst_pend;
    if (!enable) begin
      nxt = S_OFF;
      if (state != S_OFF) sub_rst_nxt = 1'b1;
    end else begin
      case (state)
        S_OFF: nxt = S_IDLE;
        S_IDLE: begin
          if (start_rise) begin
            nxt         = S_ARM;
            round_nxt   = '0;
            strikes_nxt = '0;
          end
        end
        S_ARM: begin
          if (start_fall) begin
            nxt      = S_SHOW;
            code_nxt = lfsr[CODE_W-1:0];
            secs_nxt = SHOW_T;
          end
        end
        S_SHOW: begin
          if (final_tick) begin
            nxt      = S_INPUT;
            secs_nxt = INPUT_T;
          end else if (tick) begin
            secs_nxt = secs_dec;
          end
        end
        S_INPUT: begin
          // A wrong entry outranks a simultaneous correct one; a timeout loss shows 0 s
          if (code_bad) begin
            strikes_nxt = strikes_inc;
            if (strikes_inc == STRIKE_LIM) begin
              nxt      = S_LOSE;
              secs_nxt = END_T;
              hold_nxt = END_T;
            end else if (final_tick) begin
              nxt      = S_LOSE;
              secs_nxt = '0;
              hold_nxt = END_T;
            end else if (tick) begin
              secs_nxt = secs_dec;
            end
          end else if (code_ok) begin
            if (round == LAST_ROUND) begin
              nxt      = S_WIN;
              secs_nxt = END_T;
              hold_nxt = END_T;
            end else begin
              nxt         = S_SHOW;
              round_nxt   = round + ROUND_W'(1);
              code_nxt    = lfsr[CODE_W-1:0];
              secs_nxt    = SHOW_T;
              sub_rst_nxt = 1'b1;
            end
          end else if (final_tick) begin
            nxt      = S_LOSE;
            secs_nxt = '0;
            hold_nxt = END_T;
          end else if (tick) begin
            secs_nxt = secs_dec;
          end
        end
        S_WIN, S_LOSE: begin
          // hold_cnt times the result even when secs_left already reads 0
          if ((AUTO_RESTART == 0) && start_rise) begin
            nxt         = S_ARM;
            round_nxt   = '0;
            strikes_nxt = '0;
          end else if (tick) begin
            secs_nxt = secs_dec;
            hold_nxt = (hold_cnt != '0) ? hold_cnt - TIME_W'(1) : hold_cnt;
            if ((AUTO_RESTART != 0) && (hold_cnt <= TIME_W'(1))) begin
              nxt         = S_IDLE;
              sub_rst_nxt = 1'b1;
            end
          end
        end
        default: nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state      <= S_OFF;
      lfsr       <= 16'hACE1;
      start_prev <= 1'b0;
      rst_pend   <= 1'b1;
      sub_rst    <= 1'b1;
      bomb_en    <= 1'b0;
      show_en    <= 1'b0;
      input_en   <= 1'b0;
      timer_en   <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      code       <= '0;
      secs_left  <= '0;
      hold_cnt   <= '0;
      round      <= '0;
      strikes    <= '0;
    end else begin
      state      <= nxt;
      lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      start_prev <= start_btn;
      rst_pend   <= 1'b0;
      sub_rst    <= sub_rst_nxt;
      bomb_en    <= (nxt == S_SHOW) || (nxt == S_INPUT);
      show_en    <= (nxt == S_SHOW);
      input_en   <= (nxt == S_INPUT);
      timer_en   <= (nxt == S_INPUT);
      win        <= (nxt == S_WIN);
      lose       <= (nxt == S_LOSE);
      code       <= code_nxt;
      secs_left  <= secs_nxt;
      hold_cnt   <= hold_nxt;
      round      <= round_nxt;
      strikes    <= strikes_nxt;
    end
  end

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Bench for bomb_game_ctrl: two instances (auto-restart on/off) share stimulus and are
// checked every cycle against an event-level game model, plus hand-computed spot checks.
`timescale 1ns/1ps
module tb_bomb_game_ctrl;

  localparam int CODE_W = 5, TIME_W = 5, ROUND_W = 2;
  localparam int SHOW_SEC = 5, INPUT_SEC = 20, ROUNDS = 3, MAX_STRIKES = 2, END_SEC = 3;
  localparam int P_OFF = 0, P_IDLE = 1, P_ARM = 2, P_SHOW = 3, P_INPUT = 4, P_WIN = 5, P_LOSE = 6;

  typedef struct {
    logic [15:0] lfsr;
    int phase, code, secs, hold, round, strikes;
    bit subr, prev, pend;
  } mstate_t;

  logic clk = 0, Rst = 0, enable = 0, start_btn = 0, tick = 0, code_ok = 0, code_bad = 0;
  logic sub_rst_a, bomb_en_a, show_en_a, input_en_a, timer_en_a, win_a, lose_a;
  logic sub_rst_b, bomb_en_b, show_en_b, input_en_b, timer_en_b, win_b, lose_b;
  logic [CODE_W-1:0] code_a, code_b;
  logic [TIME_W-1:0] secs_a, secs_b;
  logic [ROUND_W-1:0] round_a, round_b;
  logic [1:0] strikes_a, strikes_b;

  int n_cmp = 0, n_fail = 0;
  bit cmp_on = 0;
  mstate_t m_a, m_b;

  always #5 clk = ~clk;

  bomb_game_ctrl #(.AUTO_RESTART(1)) dut_a (
    .clk(clk), .Rst(Rst), .enable(enable), .start_btn(start_btn), .tick(tick),
    .code_ok(code_ok), .code_bad(code_bad), .sub_rst(sub_rst_a), .bomb_en(bomb_en_a),
    .show_en(show_en_a), .input_en(input_en_a), .timer_en(timer_en_a), .code(code_a),
    .secs_left(secs_a), .round(round_a), .strikes(strikes_a), .win(win_a), .lose(lose_a));

  bomb_game_ctrl #(.AUTO_RESTART(0)) dut_b (
    .clk(clk), .Rst(Rst), .enable(enable), .start_btn(start_btn), .tick(tick),
    .code_ok(code_ok), .code_bad(code_bad), .sub_rst(sub_rst_b), .bomb_en(bomb_en_b),
    .show_en(show_en_b), .input_en(input_en_b), .timer_en(timer_en_b), .code(code_b),
    .secs_left(secs_b), .round(round_b), .strikes(strikes_b), .win(win_b), .lose(lose_b));

  // One clock of the game rules: what the controller must look like after this edge
  function automatic mstate_t model_step(mstate_t s, bit rst_n, bit en, bit st, bit tk,
                                         bit ok, bit bad, bit auto_rs);
    mstate_t n;
    bit rise, fall, timeout;
    n = s;
    n.subr = 0;
    if (!rst_n) begin
      n.lfsr = 16'hACE1; n.phase = P_OFF; n.code = 0; n.secs = 0; n.hold = 0;
      n.round = 0; n.strikes = 0; n.subr = 1; n.prev = 0; n.pend = 1;
      return n;
    end
    n.lfsr = {s.lfsr[0] ^ s.lfsr[2] ^ s.lfsr[3] ^ s.lfsr[5], s.lfsr[15:1]};
    n.prev = st;
    n.pend = 0;
    if (s.pend) n.subr = 1;
    rise = st && !s.prev;
    fall = !st && s.prev;
    timeout = tk && (s.secs == 1);
    if (!en) begin
      if (s.phase != P_OFF) n.subr = 1;
      n.phase = P_OFF;
      return n;
    end
    if (s.phase == P_OFF) n.phase = P_IDLE;
    else if (s.phase == P_IDLE && rise) begin
      n.phase = P_ARM; n.round = 0; n.strikes = 0;
    end else if (s.phase == P_ARM && fall) begin
      n.phase = P_SHOW; n.code = s.lfsr % (1 << CODE_W); n.secs = SHOW_SEC;
    end else if (s.phase == P_SHOW && tk) begin
      if (timeout) begin n.phase = P_INPUT; n.secs = INPUT_SEC; end
      else if (s.secs > 0) n.secs = s.secs - 1;
    end else if (s.phase == P_INPUT) begin
      if (bad) begin
        n.strikes = s.strikes + 1;
        if (n.strikes == MAX_STRIKES) begin n.phase = P_LOSE; n.secs = END_SEC; n.hold = END_SEC; end
        else if (timeout) begin n.phase = P_LOSE; n.secs = 0; n.hold = END_SEC; end
        else if (tk && s.secs > 0) n.secs = s.secs - 1;
      end else if (ok) begin
        if (s.round == ROUNDS - 1) begin n.phase = P_WIN; n.secs = END_SEC; n.hold = END_SEC; end
        else begin
          n.phase = P_SHOW; n.round = s.round + 1; n.code = s.lfsr % (1 << CODE_W);
          n.secs = SHOW_SEC; n.subr = 1;
        end
      end else if (timeout) begin n.phase = P_LOSE; n.secs = 0; n.hold = END_SEC; end
      else if (tk && s.secs > 0) n.secs = s.secs - 1;
    end else if (s.phase == P_WIN || s.phase == P_LOSE) begin
      if (!auto_rs && rise) begin
        n.phase = P_ARM; n.round = 0; n.strikes = 0;
      end else if (tk) begin
        n.secs = (s.secs > 0) ? s.secs - 1 : 0;
        n.hold = (s.hold > 0) ? s.hold - 1 : 0;
        if (auto_rs && s.hold <= 1) begin n.phase = P_IDLE; n.subr = 1; end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_a <= model_step(m_a, Rst, enable, start_btn, tick, code_ok, code_bad, 1'b1);
    m_b <= model_step(m_b, Rst, enable, start_btn, tick, code_ok, code_bad, 1'b0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h, required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareDut(input string tag, input mstate_t m, input logic sr, input logic bo,
                            input logic sh, input logic ie, input logic te, input logic w,
                            input logic l, input logic [CODE_W-1:0] cd, input logic [TIME_W-1:0] sc,
                            input logic [ROUND_W-1:0] rd, input logic [1:0] sk);
    checkOutput({tag, ".sub_rst"},  sr, m.subr);
    checkOutput({tag, ".bomb_en"},  bo, m.phase == P_SHOW || m.phase == P_INPUT);
    checkOutput({tag, ".show_en"},  sh, m.phase == P_SHOW);
    checkOutput({tag, ".input_en"}, ie, m.phase == P_INPUT);
    checkOutput({tag, ".timer_en"}, te, m.phase == P_INPUT);
    checkOutput({tag, ".win"},      w,  m.phase == P_WIN);
    checkOutput({tag, ".lose"},     l,  m.phase == P_LOSE);
    checkOutput({tag, ".code"},     cd, m.code);
    checkOutput({tag, ".round"},    rd, m.round);
    checkOutput({tag, ".strikes"},  sk, m.strikes);
    if (m.phase >= P_SHOW) checkOutput({tag, ".secs_left"}, sc, m.secs);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      compareDut("A", m_a, sub_rst_a, bomb_en_a, show_en_a, input_en_a, timer_en_a, win_a, lose_a,
                 code_a, secs_a, round_a, strikes_a);
      compareDut("B", m_b, sub_rst_b, bomb_en_b, show_en_b, input_en_b, timer_en_b, win_b, lose_b,
                 code_b, secs_b, round_b, strikes_b);
    end
  end

  task automatic applyStimulus(input bit rst_n, input bit en, input bit st, input bit tk,
                               input bit ok, input bit bad);
    Rst = rst_n; enable = en; start_btn = st; tick = tk; code_ok = ok; code_bad = bad;
    @(negedge clk);
  endtask

  task automatic step(input bit tk, input bit ok, input bit bad);
    applyStimulus(1'b1, enable, start_btn, tk, ok, bad);
  endtask

  task automatic doTick();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressRelease(input int hold_cycles);
    repeat (hold_cycles) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset and power-up
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp_on = 1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_sub_rst", sub_rst_a, 1);
    checkOutput("reset_bomb_en", bomb_en_a, 0);
    checkOutput("reset_secs", secs_a, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("release_sub_rst", sub_rst_a, 1);
    checkOutput("release_code", code_a, 0);
    checkOutput("model_lfsr_1", m_a.lfsr, 16'h5670);
    step(1'b0, 1'b0, 1'b0);
    checkOutput("sub_rst_one_cycle", sub_rst_a, 0);
    checkOutput("model_lfsr_2", m_a.lfsr, 16'hAB38);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    checkOutput("idle_ignores_events", strikes_a, 0);

    // first round: display then entry
    pressRelease(10);
    checkOutput("show_en_on", show_en_a, 1);
    checkOutput("show_secs", secs_a, 5);
    checkOutput("show_timer_off", timer_en_a, 0);
    step(1'b0, 1'b0, 1'b1);
    repeat (4) doTick();
    checkOutput("show_secs_last", secs_a, 1);
    doTick();
    checkOutput("input_en_on", input_en_a, 1);
    checkOutput("input_timer_on", timer_en_a, 1);
    checkOutput("input_secs", secs_a, 20);

    // three correct entries win the game
    step(1'b0, 1'b1, 1'b0);
    checkOutput("ok_round1", round_a, 1);
    checkOutput("ok_sub_rst", sub_rst_a, 1);
    checkOutput("ok_back_to_show", secs_a, 5);
    repeat (5) doTick();
    step(1'b0, 1'b1, 1'b0);
    checkOutput("ok_round2", round_a, 2);
    repeat (5) doTick();
    step(1'b0, 1'b1, 1'b0);
    checkOutput("win_on", win_a, 1);
    checkOutput("win_bomb_off", bomb_en_a, 0);
    checkOutput("win_secs", secs_a, 3);
    repeat (2) doTick();
    step(1'b1, 1'b0, 1'b0);
    checkOutput("win_expire_a", win_a, 0);
    checkOutput("win_expire_sub_rst", sub_rst_a, 1);
    checkOutput("win_hold_b", win_b, 1);
    checkOutput("win_hold_secs_b", secs_b, 0);
    step(1'b0, 1'b0, 1'b0);
    checkOutput("restart_sub_rst_drop", sub_rst_a, 0);
    repeat (2) doTick();
    checkOutput("win_still_b", win_b, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("win_b_start_clears", win_b, 0);
    pressRelease(3);
    checkOutput("b_show_again", show_en_b, 1);

    // strike-out loss, then timeout loss
    repeat (5) doTick();
    step(1'b0, 1'b0, 1'b1);
    checkOutput("strike_1", strikes_a, 1);
    checkOutput("strike_1_no_lose", lose_a, 0);
    doTick();
    step(1'b0, 1'b0, 1'b1);
    checkOutput("strike_out_lose", lose_a, 1);
    checkOutput("strike_out_secs", secs_a, 3);
    repeat (3) doTick();
    checkOutput("lose_expire_a", lose_a, 0);
    checkOutput("lose_hold_b", lose_b, 1);
    pressRelease(3);
    checkOutput("new_game_strikes", strikes_a, 0);
    repeat (5) doTick();
    repeat (19) doTick();
    checkOutput("timeout_secs_1", secs_a, 1);
    step(1'b1, 1'b0, 1'b0);
    checkOutput("timeout_lose", lose_a, 1);
    checkOutput("timeout_secs_0", secs_a, 0);
    step(1'b0, 1'b0, 1'b0);
    repeat (3) doTick();
    pressRelease(2);

    // simultaneous events in INPUT
    repeat (5) doTick();
    repeat (19) doTick();
    step(1'b1, 1'b1, 1'b0);
    checkOutput("ok_beats_tick_round", round_a, 1);
    checkOutput("ok_beats_tick_lose", lose_a, 0);
    step(1'b0, 1'b0, 1'b0);
    repeat (5) doTick();
    step(1'b0, 1'b1, 1'b1);
    checkOutput("ok_bad_strikes", strikes_a, 1);
    checkOutput("ok_bad_round", round_a, 1);
    checkOutput("ok_bad_stay", input_en_a, 1);

    // master switch off mid-entry, then back on
    doTick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("off_input_en", input_en_a, 0);
    checkOutput("off_bomb_en", bomb_en_a, 0);
    checkOutput("off_sub_rst", sub_rst_a, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("off_sub_rst_once", sub_rst_a, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reenable_bomb_off", bomb_en_a, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
